serial_word_comparator: RTL

//  Digit-serial magnitude comparator for two WIDTH-bit operands, fed MSB-digit first at DIGIT bits per accepted beat.

---
 rtl/serial_word_comparator.sv | 115 +++++++++++
 1 files changed

// File: rtl/serial_word_comparator.sv
// serial_word_comparator: digit-serial (MSB-first) signed/unsigned g/e/l comparator.
// Optional SERIAL_CMP_EARLY_EXIT_EN ends the compare on the first deciding digit.
`default_nettype none

module serial_word_comparator #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic             in_valid_i,
  input  logic             signed_mode_i,
  input  logic [DIGIT-1:0] a_i,
  input  logic [DIGIT-1:0] b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             g_o,
  output logic             e_o,
  output logic             l_o
);

  localparam int             NDIG   = WIDTH / DIGIT;
  localparam int             CW     = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [CW-1:0]  LAST   = CW'(NDIG - 1);
  localparam logic [CW-1:0]  FIRST  = (NDIG > 1) ? CW'(1) : CW'(0);
  localparam logic           SINGLE = (NDIG == 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  state_e          state_q;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            busy_q, done_q;
  logic            g_q, e_q, l_q;
  logic            g_d, e_d, l_d;

  logic             accept;
  logic             last_digit;
  logic             early;
  logic             finish;
  logic [DIGIT-1:0] da, db;

  always_comb begin
    accept = start_i | ((state_q == RUN) & in_valid_i);

    // Offset-binary: flipping the sign bit makes the MSB digit compare as unsigned.
    da = a_i;
    db = b_i;
    if (start_i && signed_mode_i) begin
      da[DIGIT-1] = ~a_i[DIGIT-1];
      db[DIGIT-1] = ~b_i[DIGIT-1];
    end

    g_d = g_q;
    e_d = e_q;
    l_d = l_q;
    if (accept && (start_i || e_q)) begin
      g_d = (da > db);
      e_d = (da == db);
      l_d = (da < db);
    end

    last_digit = start_i ? SINGLE : (cnt_q == LAST);
`ifdef SERIAL_CMP_EARLY_EXIT_EN
    early = g_d | l_d;
`else
    early = 1'b0;
`endif
    finish = accept & (last_digit | early);

    cnt_d = cnt_q;
    if (start_i) begin
      cnt_d = FIRST;
    end else if (accept && (cnt_q != LAST)) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      g_q     <= 1'b0;
      e_q     <= 1'b1;
      l_q     <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      g_q    <= g_d;
      e_q    <= e_d;
      l_q    <= l_d;
      done_q <= finish;
      if (finish) begin
        state_q <= IDLE;
        busy_q  <= 1'b0;
      end else if (start_i) begin
        state_q <= RUN;
        busy_q  <= 1'b1;
      end
    end
  end

  assign busy_o = busy_q;
  assign done_o = done_q;
  assign g_o    = g_q;
  assign e_o    = e_q;
  assign l_o    = l_q;

endmodule

`default_nettype wire
